// File: rtl/div_pkg.sv
// Shared types and default sizing for the HI/LO divide sequencer.
package div_pkg;

    localparam int unsigned DEFAULT_WIDTH         = 32;
    localparam int unsigned DEFAULT_SETTLE_CYCLES = 4;
    localparam int unsigned CNT_W                 = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : div_pkg

// File: rtl/div_hilo_sequencer_if.sv
// Requester/divider-side signal bundle of the HI/LO divide sequencer.
interface div_hilo_sequencer_if #(
    parameter int unsigned WIDTH = div_pkg::DEFAULT_WIDTH
);

    logic               start;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [WIDTH-1:0]   div_a;
    logic [WIDTH-1:0]   div_b;
    logic [2*WIDTH-1:0] div_z;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    logic [WIDTH-1:0]   hi_out;
    logic [WIDTH-1:0]   lo_out;

    // Sequencer side
    modport slave (
        input  start, a_in, b_in, div_z,
        output div_a, div_b, busy, done, div_by_zero, hi_out, lo_out
    );

    // Requester plus external divider side
    modport master (
        output start, a_in, b_in, div_z,
        input  div_a, div_b, busy, done, div_by_zero, hi_out, lo_out
    );

endinterface : div_hilo_sequencer_if

// File: rtl/div_hilo_sequencer_settle_counter.sv
// 4-bit loadable down-counter timing the external divider's settle window.
module settle_counter
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_c = (count_q == '0);

endmodule : settle_counter

// File: rtl/div_hilo_sequencer.sv
// Sequences one divide through an external combinational divider and
// captures {remainder, quotient} into HI/LO, flagging divide-by-zero.
module div_hilo_sequencer
    import div_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                 clock,
    input  logic                 clear,
    div_hilo_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             b_zero;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_zero;

    assign accept = (state_q == IDLE) && bus.start;
    assign b_zero = (bus.b_in == '0);

    settle_counter u_settle_counter (
        .clk        (clock),
        .rst_n      (clear),
        .load_i     (cnt_load),
        .load_val_i (SETTLE_LOAD),
        .en_i       (cnt_en),
        .zero_c     (cnt_zero)
    );

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero divisor skips the settle window entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = b_zero ? DONE : WAIT;
            WAIT:    if (cnt_zero)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; div_z is only looked at on the WAIT->DONE edge
    always_comb begin
        div_a_d  = div_a_q;
        div_b_d  = div_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        if (accept) begin
            div_a_d  = bus.a_in;
            div_b_d  = bus.b_in;
            dbz_d    = b_zero;
            cnt_load = !b_zero;
        end

        if (state_q == WAIT) begin
            if (cnt_zero) begin
                hi_d = bus.div_z[2*WIDTH-1:WIDTH];
                lo_d = bus.div_z[WIDTH-1:0];
            end else begin
                cnt_en = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Output registers
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            div_a_q <= '0;
            div_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            div_a_q <= div_a_d;
            div_b_q <= div_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.div_a       = div_a_q;
    assign bus.div_b       = div_b_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule : div_hilo_sequencer

// File: tb/tb_div_hilo_sequencer.sv
// Directed bench for div_hilo_sequencer with a behavioural divider on div_a/div_b.
module tb_div_hilo_sequencer;

    localparam int unsigned W = 32;

    logic clock;
    logic clear;
    int   n_pass;
    int   n_total;

    div_hilo_sequencer_if #(.WIDTH(W)) bus ();

    div_hilo_sequencer #(.WIDTH(W), .SETTLE_CYCLES(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // Behavioural divider: {remainder, quotient}
    assign bus.div_z = (bus.div_b != '0) ? {bus.div_a % bus.div_b, bus.div_a / bus.div_b}
                                         : '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0; bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0;
        #3;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0d want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %0d want 0", bus.done); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset_dbz got %0d want 0", bus.div_by_zero); else n_pass++;
        n_total++; if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0)
            $display("FAIL reset_hilo got %0h/%0h want 0/0", bus.hi_out, bus.lo_out); else n_pass++;
        n_total++; if (bus.div_a !== 32'd0 || bus.div_b !== 32'd0)
            $display("FAIL reset_div_ab got %0h/%0h want 0/0", bus.div_a, bus.div_b); else n_pass++;
        step();
        step();
        clear = 1'b1;
    endtask

    // 100/7 started in the very first cycle after reset release
    task automatic test_normal();
        bus.a_in = 32'd100; bus.b_in = 32'd7; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            n_total++; if (bus.busy !== (c <= 5)) $display("FAIL normal_busy c%0d got %0d want %0d", c, bus.busy, (c <= 5)); else n_pass++;
            n_total++; if (bus.done !== (c == 5)) $display("FAIL normal_done c%0d got %0d want %0d", c, bus.done, (c == 5)); else n_pass++;
            if (c == 1) begin
                n_total++; if (bus.div_a !== 32'd100 || bus.div_b !== 32'd7)
                    $display("FAIL normal_div_ab got %0d/%0d want 100/7", bus.div_a, bus.div_b); else n_pass++;
            end
            if (c == 5) begin
                n_total++; if (bus.hi_out !== 32'd2) $display("FAIL normal_hi got %0d want 2", bus.hi_out); else n_pass++;
                n_total++; if (bus.lo_out !== 32'd14) $display("FAIL normal_lo got %0d want 14", bus.lo_out); else n_pass++;
                n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL normal_dbz got %0d want 0", bus.div_by_zero); else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_div_zero();
        bus.a_in = 32'd55; bus.b_in = 32'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_total++; if (bus.done !== 1'b1) $display("FAIL dz_done c1 got %0d want 1", bus.done); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL dz_busy c1 got %0d want 1", bus.busy); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b1) $display("FAIL dz_flag got %0d want 1", bus.div_by_zero); else n_pass++;
        n_total++; if (bus.hi_out !== 32'd2 || bus.lo_out !== 32'd14)
            $display("FAIL dz_hilo_keep got %0d/%0d want 2/14", bus.hi_out, bus.lo_out); else n_pass++;
        step();
        n_total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL dz_idle c2 got done=%0d busy=%0d want 0/0", bus.done, bus.busy); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b1) $display("FAIL dz_flag_hold got %0d want 1", bus.div_by_zero); else n_pass++;
    endtask

    // start held high: one accept every 6 cycles (20/6 -> q3 r2)
    task automatic test_back_to_back();
        bus.a_in = 32'd20; bus.b_in = 32'd6; bus.start = 1'b1;
        step();
        for (int c = 1; c <= 18; c++) begin
            n_total++; if (bus.busy !== ((c % 6) != 0)) $display("FAIL b2b_busy c%0d got %0d want %0d", c, bus.busy, ((c % 6) != 0)); else n_pass++;
            n_total++; if (bus.done !== ((c % 6) == 5)) $display("FAIL b2b_done c%0d got %0d want %0d", c, bus.done, ((c % 6) == 5)); else n_pass++;
            if (c == 18) bus.start = 1'b0;
            step();
        end
        n_total++; if (bus.busy !== 1'b0) $display("FAIL b2b_end_busy got %0d want 0", bus.busy); else n_pass++;
        n_total++; if (bus.hi_out !== 32'd2 || bus.lo_out !== 32'd3)
            $display("FAIL b2b_hilo got %0d/%0d want 2/3", bus.hi_out, bus.lo_out); else n_pass++;
    endtask

    // start with b=0 raised during WAIT and DONE must be dropped, not queued
    task automatic test_ignored();
        bus.a_in = 32'd50; bus.b_in = 32'd5; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 2) begin bus.start = 1'b1; bus.a_in = 32'd77; bus.b_in = 32'd0; end
            n_total++; if (bus.done !== (c == 5)) $display("FAIL ign_done c%0d got %0d want %0d", c, bus.done, (c == 5)); else n_pass++;
            n_total++; if (bus.busy !== (c <= 5)) $display("FAIL ign_busy c%0d got %0d want %0d", c, bus.busy, (c <= 5)); else n_pass++;
            if (c == 5) begin
                bus.start = 1'b0;
                n_total++; if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd10)
                    $display("FAIL ign_hilo got %0d/%0d want 0/10", bus.hi_out, bus.lo_out); else n_pass++;
                n_total++; if (bus.div_a !== 32'd50) $display("FAIL ign_div_a got %0d want 50", bus.div_a); else n_pass++;
            end
            step();
        end
        n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL ign_dbz got %0d want 0", bus.div_by_zero); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        bus.a_in = 32'd1000; bus.b_in = 32'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        clear = 1'b0;
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy got %0d want 0", bus.busy); else n_pass++;
        n_total++; if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0)
            $display("FAIL rst_mid_hilo got %0h/%0h want 0/0", bus.hi_out, bus.lo_out); else n_pass++;
        step();
        clear = 1'b1;
        for (int c = 0; c < 6; c++) begin
            n_total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL rst_mid_quiet c%0d got done=%0d busy=%0d want 0/0", c, bus.done, bus.busy); else n_pass++;
            step();
        end
        n_total++; if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0)
            $display("FAIL rst_mid_hilo_after got %0h/%0h want 0/0", bus.hi_out, bus.lo_out); else n_pass++;
    endtask

    task automatic test_input_toggle();
        bus.a_in = 32'hFFFF; bus.b_in = 32'h10; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            bus.a_in = $urandom;
            bus.b_in = $urandom;
            #1;
            n_total++; if (bus.div_a !== 32'hFFFF || bus.div_b !== 32'h10)
                $display("FAIL tog_div_ab c%0d got %0h/%0h want ffff/10", c, bus.div_a, bus.div_b); else n_pass++;
            if (c == 5) begin
                n_total++; if (bus.done !== 1'b1) $display("FAIL tog_done got %0d want 1", bus.done); else n_pass++;
                n_total++; if (bus.hi_out !== 32'hF || bus.lo_out !== 32'hFFF)
                    $display("FAIL tog_hilo got %0h/%0h want f/fff", bus.hi_out, bus.lo_out); else n_pass++;
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_dbz_then_normal();
        bus.a_in = 32'd1; bus.b_in = 32'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_total++; if (bus.div_by_zero !== 1'b1) $display("FAIL dzn_flag_set got %0d want 1", bus.div_by_zero); else n_pass++;
        step();
        bus.a_in = 32'd9; bus.b_in = 32'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) begin
                n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL dzn_flag_clear got %0d want 0", bus.div_by_zero); else n_pass++;
            end
            if (c == 5) begin
                n_total++; if (bus.done !== 1'b1) $display("FAIL dzn_done got %0d want 1", bus.done); else n_pass++;
                n_total++; if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd3)
                    $display("FAIL dzn_hilo got %0d/%0d want 0/3", bus.hi_out, bus.lo_out); else n_pass++;
            end
            step();
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_normal();
        test_div_zero();
        test_back_to_back();
        test_ignored();
        test_reset_mid_wait();
        test_input_toggle();
        test_dbz_then_normal();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_div_hilo_sequencer

// File: doc/div_hilo_sequencer.md
DIV_HILO_SEQUENCER -- requirements
Module: div_hilo_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, default 32, operand width.
- SETTLE_CYCLES, default 4, clock cycles allowed for the combinational divider to settle; legal range 1..15.

REQ-002 The block SHALL have these ports:
- clock  in  1  single clock; all state changes on the rising edge.
- clear  in  1  reset, asynchronous, active-low.
- start  in  1  request a divide; sampled only in IDLE.
- a_in  in  WIDTH  dividend.
- b_in  in  WIDTH  divisor.
- div_a  out  WIDTH  registered dividend driven to the divider.
- div_b  out  WIDTH  registered divisor driven to the divider.
- div_z  in  2*WIDTH  divider result, packed as {remainder, quotient}.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  status of the most recent operation.
- hi_out  out  WIDTH  HI register (remainder).
- lo_out  out  WIDTH  LO register (quotient).

Function
REQ-003 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-004 In IDLE with start=1, the block SHALL load div_a<=a_in and div_b<=b_in.
- If b_in==0, it SHALL go to DONE.
- Otherwise it SHALL go to WAIT with the settle counter loaded to SETTLE_CYCLES-1.
REQ-005 In WAIT, the counter SHALL decrement each cycle.
- When the counter is 0, the block SHALL load hi_out<=div_z[2*WIDTH-1:WIDTH] and lo_out<=div_z[WIDTH-1:0], then go to DONE.
REQ-006 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unconditionally.
REQ-007 Latency:
- Normal divide: start is sampled at edge 0 and done is high in cycle SETTLE_CYCLES+1.
- Divide by zero: done is high in the cycle immediately after the start edge.
REQ-008 For a divide by zero, the block SHALL:
- Set div_by_zero=1.
- Leave hi_out and lo_out unchanged.
- Never sample div_z.
REQ-009 For a nonzero divisor, the block SHALL clear div_by_zero at the start edge.
REQ-010 div_by_zero SHALL hold its value until the next accepted start.
REQ-011 start SHALL be ignored in WAIT and DONE; the ignored request SHALL NOT be queued.
REQ-012 div_a and div_b SHALL remain stable from the start edge until the block returns to IDLE.
REQ-013 a_in and b_in changes SHALL NOT affect an operation in progress.
REQ-014 hi_out and lo_out SHALL change only on entry to DONE from WAIT; they hold their values at all other times.
REQ-015 The block SHALL pass div_z bits unmodified, with no sign correction.
REQ-016 done and busy SHALL be decoded from registered state only, with no combinational path from start.

Reset
REQ-017 When clear=0, the block SHALL immediately, without waiting for a clock edge:
- Enter IDLE.
- Set the counter, div_a, div_b, hi_out and lo_out to 0.
- Set done, busy and div_by_zero to 0.
REQ-018 A reset asserted mid-WAIT SHALL abort the operation: no done pulse, and HI/LO stay 0.
REQ-019 In the first cycle after clear is released, start SHALL be accepted normally.

Structure
REQ-020 Package div_pkg SHALL hold:
- The state enumeration: IDLE=2'b00, WAIT=2'b01, DONE=2'b10.
- The default WIDTH and SETTLE_CYCLES constants.
REQ-021 The settle counter SHALL be a 4-bit down-counter sub-module named settle_counter, with load, enable and zero-flag.
REQ-022 The block SHALL contain no arithmetic beyond the counter decrement and the zero compare on b_in.

Verification
REQ-023 The bench SHALL use a behavioural divider model on div_a/div_b/div_z and SETTLE_CYCLES=4, and SHALL cover:
- a=100, b=7, start at edge 0 -> busy=1 cycles 1-5; done=1 in cycle 5 only; hi_out=2, lo_out=14; div_by_zero=0.
- a=55, b=0 -> done=1 in cycle 1; div_by_zero=1; hi_out and lo_out keep their prior values (2, 14).
- start held high continuously -> operations complete every 6 cycles; no start is accepted while busy=1.
- clear pulled low in cycle 3 of a 1000/3 divide -> done never pulses; hi_out=lo_out=0; busy=0 immediately.
- a_in and b_in toggled randomly during WAIT of 0xFFFF/0x10 -> div_a and div_b stay stable; hi_out=0xF, lo_out=0xFFF.
- Divide by zero followed by 9/3 -> div_by_zero clears at the start edge; hi_out=0, lo_out=3.
